// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing generator.
//   mode_e    : test-pattern selector encodings
//   timing_t  : one complete video-mode timing set
//   TIMING_*  : standard timing sets for 800x600@60 and 640x480@60
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_BORDER   = 2'd0,
    MODE_BARS     = 2'd1,
    MODE_CHECKER  = 2'd2,
    MODE_GRADIENT = 2'd3
  } mode_e;

  typedef struct packed {
    int   h_visible;
    int   h_front;
    int   h_sync;
    int   h_back;
    int   v_visible;
    int   v_front;
    int   v_sync;
    int   v_back;
    logic h_pol;
    logic v_pol;
  } timing_t;

  // 800x600@60, 40 MHz pixel clock, both syncs active-high.
  localparam timing_t TIMING_800X600_60 = '{800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1};
  // 640x480@60, 25.175 MHz pixel clock, both syncs active-low.
  localparam timing_t TIMING_640X480_60 = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};

  function automatic int h_total(input timing_t t);
    return t.h_visible + t.h_front + t.h_sync + t.h_back;
  endfunction

  function automatic int v_total(input timing_t t);
    return t.v_visible + t.v_front + t.v_sync + t.v_back;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video output bundle between the timing generator and the downstream encoder.
//   mode        : requested test pattern (from the consumer side)
//   red/green/blue, hsync, vsync, blank : registered video signals
//   x, y        : pixel coordinates matching the current video signals
//   frame_start : one-cycle strobe while (0,0) is on the outputs
//   frame_count : frames completed since reset, wraps at 256
// master = timing generator, slave = encoder/consumer.
interface vga_timing_gen_if #(
  parameter int COLOR_BITS = 3
);
  logic [1:0]            mode;
  logic [COLOR_BITS-1:0] red;
  logic [COLOR_BITS-1:0] green;
  logic [COLOR_BITS-1:0] blue;
  logic                  hsync;
  logic                  vsync;
  logic                  blank;
  logic [10:0]           x;
  logic [9:0]            y;
  logic                  frame_start;
  logic [7:0]            frame_count;

  modport master (
    input  mode,
    output red, green, blue, hsync, vsync, blank, x, y, frame_start, frame_count
  );

  modport slave (
    output mode,
    input  red, green, blue, hsync, vsync, blank, x, y, frame_start, frame_count
  );
endinterface

// File: rtl/vga_pattern.sv
// Combinational test-pattern colour for one pixel.
//   x, y        : pixel coordinates (assumed inside the visible area)
//   mode        : pattern to draw
//   frame_count : frame number shown with this pixel (gradient blue channel)
//   red/green/blue : colour; blanking is applied by the caller
module vga_pattern
  import vga_pkg::*;
#(
  parameter int H_VISIBLE  = 800,
  parameter int V_VISIBLE  = 600,
  parameter int COLOR_BITS = 3,
  parameter int BORDER     = 10
) (
  input  logic [10:0]           x,
  input  logic [9:0]            y,
  input  mode_e                 mode,
  input  logic [7:0]            frame_count,
  output logic [COLOR_BITS-1:0] red,
  output logic [COLOR_BITS-1:0] green,
  output logic [COLOR_BITS-1:0] blue
);

  localparam int          BAR_W = H_VISIBLE / 8;
  localparam logic [10:0] X_LO  = 11'(BORDER);
  localparam logic [10:0] X_HI  = 11'(H_VISIBLE - BORDER);
  localparam logic [9:0]  Y_LO  = 10'(BORDER);
  localparam logic [9:0]  Y_HI  = 10'(V_VISIBLE - BORDER);

  logic [2:0] bar;
  logic       in_border;

  always_comb begin
    // Bar index by threshold compare; the last bar absorbs any H_VISIBLE%8 remainder.
    bar = '0;
    for (int unsigned i = 1; i < 8; i++) begin
      if ({21'b0, x} >= i * BAR_W) bar = 3'(i);
    end

    in_border = (x < X_LO) || (x >= X_HI) || (y < Y_LO) || (y >= Y_HI);

    red   = '0;
    green = '0;
    blue  = '0;
    case (mode)
      MODE_BORDER: begin
        if (in_border) blue = '1;
      end
      MODE_BARS: begin
        red   = {COLOR_BITS{bar[2]}};
        green = {COLOR_BITS{bar[1]}};
        blue  = {COLOR_BITS{bar[0]}};
      end
      MODE_CHECKER: begin
        if (x[5] ^ y[5]) begin
          red   = '1;
          green = '1;
          blue  = '1;
        end
      end
      MODE_GRADIENT: begin
        // Top COLOR_BITS of bits [7:0]
        red   = COLOR_BITS'(x[7:0] >> (8 - COLOR_BITS));
        green = COLOR_BITS'(y[7:0] >> (8 - COLOR_BITS));
        blue  = COLOR_BITS'(frame_count >> (8 - COLOR_BITS));
      end
    endcase
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing and test-pattern generator.
//   clk   : pixel clock
//   reset : synchronous, active-high
//   bus   : video bundle (mode in; colour, syncs, blank, x/y, frame_start,
//           frame_count out). All outputs are registered and show the counter
//           state of the previous cycle.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE  = 800,
  parameter int H_FRONT    = 40,
  parameter int H_SYNC     = 128,
  parameter int H_BACK     = 88,
  parameter int V_VISIBLE  = 600,
  parameter int V_FRONT    = 1,
  parameter int V_SYNC     = 4,
  parameter int V_BACK     = 23,
  parameter int H_SYNC_POL = 1,
  parameter int V_SYNC_POL = 1,
  parameter int COLOR_BITS = 3,
  parameter int BORDER     = 10
) (
  input logic              clk,
  input logic              reset,
  vga_timing_gen_if.master bus
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if (!(COLOR_BITS >= 1 && COLOR_BITS <= 8 && H_TOTAL <= 2048 && V_TOTAL <= 1024 &&
        2 * BORDER < H_VISIBLE && 2 * BORDER < V_VISIBLE)) begin : g_bad_params
    $error("vga_timing_gen: unsupported timing/colour/border parameters");
  end

  // One extra bit so sync-end bounds equal to the total still compare correctly.
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [11:0] H_VIS    = 12'(H_VISIBLE);
  localparam logic [11:0] HS_START = 12'(H_VISIBLE + H_FRONT);
  localparam logic [11:0] HS_END   = 12'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic        H_ACT    = (H_SYNC_POL != 0);
  localparam logic        V_ACT    = (V_SYNC_POL != 0);

  logic [10:0]           hcount;
  logic [9:0]            vcount;
  mode_e                 active_mode;
  logic                  first_frame;
  logic [7:0]            frame_cnt;

  logic                  at_origin;
  mode_e                 mode_next;
  logic [7:0]            fc_next;
  logic                  visible;
  logic                  hs_on;
  logic                  vs_on;
  logic [COLOR_BITS-1:0] pat_red;
  logic [COLOR_BITS-1:0] pat_green;
  logic [COLOR_BITS-1:0] pat_blue;

  logic [COLOR_BITS-1:0] red_q;
  logic [COLOR_BITS-1:0] green_q;
  logic [COLOR_BITS-1:0] blue_q;
  logic                  hsync_q;
  logic                  vsync_q;
  logic                  blank_q;
  logic [10:0]           x_q;
  logic [9:0]            y_q;
  logic                  fs_q;

  // The pixel registered at the (0,0) cycle already uses the newly latched
  // mode and frame number, so a frame is drawn entirely in one mode.
  always_comb begin
    at_origin = (hcount == '0) && (vcount == '0);
    mode_next = at_origin ? mode_e'(bus.mode) : active_mode;
    fc_next   = (at_origin && !first_frame) ? frame_cnt + 8'd1 : frame_cnt;
    visible   = ({1'b0, hcount} < H_VIS) && ({1'b0, vcount} < V_VIS);
    hs_on     = ({1'b0, hcount} >= HS_START) && ({1'b0, hcount} < HS_END);
    vs_on     = ({1'b0, vcount} >= VS_START) && ({1'b0, vcount} < VS_END);
  end

  vga_pattern #(
    .H_VISIBLE (H_VISIBLE),
    .V_VISIBLE (V_VISIBLE),
    .COLOR_BITS(COLOR_BITS),
    .BORDER    (BORDER)
  ) u_pattern (
    .x          (hcount),
    .y          (vcount),
    .mode       (mode_next),
    .frame_count(fc_next),
    .red        (pat_red),
    .green      (pat_green),
    .blue       (pat_blue)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      hcount      <= '0;
      vcount      <= '0;
      active_mode <= MODE_BORDER;
      first_frame <= 1'b1;
      frame_cnt   <= '0;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
      hsync_q     <= ~H_ACT;
      vsync_q     <= ~V_ACT;
      blank_q     <= 1'b1;
      x_q         <= '0;
      y_q         <= '0;
      fs_q        <= 1'b0;
    end else begin
      if (hcount == H_LAST) begin
        hcount <= '0;
        vcount <= (vcount == V_LAST) ? '0 : vcount + 10'd1;
      end else begin
        hcount <= hcount + 11'd1;
      end
      active_mode <= mode_next;
      first_frame <= first_frame & ~at_origin;
      frame_cnt   <= fc_next;
      red_q       <= visible ? pat_red   : '0;
      green_q     <= visible ? pat_green : '0;
      blue_q      <= visible ? pat_blue  : '0;
      hsync_q     <= hs_on ? H_ACT : ~H_ACT;
      vsync_q     <= vs_on ? V_ACT : ~V_ACT;
      blank_q     <= ~visible;
      x_q         <= hcount;
      y_q         <= vcount;
      fs_q        <= at_origin;
    end
  end

  assign bus.red         = red_q;
  assign bus.green       = green_q;
  assign bus.blue        = blue_q;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.blank       = blank_q;
  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.frame_start = fs_q;
  assign bus.frame_count = frame_cnt;

endmodule
